monitor_ciclo_cafe: RTL

Downstream observer of the `maquina_maluca` coffee FSM, consuming its 4-bit `state` output every clock. Checks each sampled transition against the legal brew graph and counts completed coffees and reservoir refills. Measures the length of each brew cycle, and latches the first violation with a code until software clears it. Its outputs feed the status and diagnostic logic; it never drives the coffee FSM.

---
 rtl/maquina_maluca_pkg.sv | 36 +++
 rtl/verifica_transicao.sv | 37 +++
 rtl/monitor_ciclo_cafe.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/maquina_maluca_pkg.sv
// Shared definitions for the coffee machine FSM and its cycle monitor:
// machine state encoding, monitor error codes and monitor FSM states.
package maquina_maluca_pkg;

  // Machine states, same encoding as the maquina_maluca state output
  localparam logic [3:0] IDLE                = 4'd1;
  localparam logic [3:0] LIGAR               = 4'd2;
  localparam logic [3:0] VERIFICAR           = 4'd3;
  localparam logic [3:0] ENCHER_RESERVATORIO = 4'd4;
  localparam logic [3:0] MOER_CAFE           = 4'd5;
  localparam logic [3:0] COLOCAR_NO_FILTRO   = 4'd6;
  localparam logic [3:0] PASSAR_AGUA         = 4'd7;
  localparam logic [3:0] TAMPEAR             = 4'd8;
  localparam logic [3:0] REALIZAR_EXTRACAO   = 4'd9;

  // Monitor error codes
  localparam logic [2:0] ERR_NENHUM      = 3'd0;
  localparam logic [2:0] ERR_CODIFICACAO = 3'd1;
  localparam logic [2:0] ERR_TRANSICAO   = 3'd2;
  localparam logic [2:0] ERR_TRAVAMENTO  = 3'd3;
  localparam logic [2:0] ERR_RECARGAS    = 3'd4;

  // Monitor FSM encoding
  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_CICLO = 2'd1,
    MON_ERRO  = 2'd2,
    MON_SYNC  = 2'd3
  } mon_estado_t;

  // True when the value is one of the nine defined machine states
  function automatic logic estado_valido(input logic [3:0] s);
    return (s >= IDLE) && (s <= REALIZAR_EXTRACAO);
  endfunction

endpackage

// File: rtl/verifica_transicao.sv
// Legality table of the brew graph: tells whether prev -> cur is an allowed
// step and whether cur is a defined state encoding. Purely combinational.
module verifica_transicao
  import maquina_maluca_pkg::*;
(
  input  logic [3:0] prev,
  input  logic [3:0] cur,
  output logic       legal,
  output logic       encoding_ok
);

  // Decode the allowed successor set of prev; self-loops are always allowed
  // here, their duration is policed separately by the hold counter.
  always_comb begin
    encoding_ok = estado_valido(cur);
    legal       = 1'b0;
    if (encoding_ok && estado_valido(prev)) begin
      if (cur == prev) begin
        legal = 1'b1;
      end else begin
        case (prev)
          IDLE:                legal = (cur == LIGAR);
          LIGAR:               legal = (cur == VERIFICAR);
          VERIFICAR:           legal = (cur == ENCHER_RESERVATORIO) || (cur == MOER_CAFE);
          ENCHER_RESERVATORIO: legal = (cur == VERIFICAR);
          MOER_CAFE:           legal = (cur == COLOCAR_NO_FILTRO);
          COLOCAR_NO_FILTRO:   legal = (cur == PASSAR_AGUA);
          PASSAR_AGUA:         legal = (cur == TAMPEAR);
          TAMPEAR:             legal = (cur == REALIZAR_EXTRACAO);
          REALIZAR_EXTRACAO:   legal = (cur == IDLE);
          default:             legal = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/monitor_ciclo_cafe.sv
// Passive observer of the maquina_maluca state output. Validates every
// sampled transition, counts completed brews, measures the last brew length
// and latches the first violation until software clears it.
module monitor_ciclo_cafe
  import maquina_maluca_pkg::*;
#(
  parameter int MAX_HOLD    = 16,
  parameter int MAX_REFILLS = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       state_in,
  input  logic             clear,
  output logic             em_ciclo,
  output logic             cafe_pronto,
  output logic [CNT_W-1:0] cafes_total,
  output logic [7:0]       ciclo_len,
  output logic             erro,
  output logic [2:0]       erro_cod,
  output logic [3:0]       erro_estado
);

  // Counters are sized to hold one step past their limit, then saturate
  localparam int HOLD_W = $clog2(MAX_HOLD + 2);
  localparam int REF_W  = $clog2(MAX_REFILLS + 2);

  mon_estado_t       estado;
  logic [3:0]        prev;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REF_W-1:0]  refill_cnt;
  logic [7:0]        len_cnt;

  logic              transicao_ok;
  logic              codificacao_ok;
  logic              self_loop;
  logic              entra_encher;
  logic              travado;
  logic              recargas_demais;
  logic [2:0]        viol_cod;

  verifica_transicao u_verifica (
    .prev        (prev),
    .cur         (state_in),
    .legal       (transicao_ok),
    .encoding_ok (codificacao_ok)
  );

  // Classify the current sample; the highest-priority violation wins
  always_comb begin
    self_loop       = (state_in == prev) && (state_in != IDLE);
    entra_encher    = (state_in == ENCHER_RESERVATORIO) && (prev != ENCHER_RESERVATORIO);
    travado         = self_loop && (hold_cnt >= HOLD_W'(MAX_HOLD));
    recargas_demais = (estado == MON_CICLO) && entra_encher &&
                      (refill_cnt >= REF_W'(MAX_REFILLS));
    viol_cod        = ERR_NENHUM;
    if (!codificacao_ok) begin
      viol_cod = ERR_CODIFICACAO;
    end else if (!transicao_ok) begin
      viol_cod = ERR_TRANSICAO;
    end else if (recargas_demais) begin
      viol_cod = ERR_RECARGAS;
    end else if (travado) begin
      viol_cod = ERR_TRAVAMENTO;
    end
  end

  // Monitor FSM with all statistics and outputs registered alongside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado      <= MON_IDLE;
      prev        <= IDLE;
      hold_cnt    <= '0;
      refill_cnt  <= '0;
      len_cnt     <= '0;
      em_ciclo    <= 1'b0;
      cafe_pronto <= 1'b0;
      cafes_total <= '0;
      ciclo_len   <= '0;
      erro        <= 1'b0;
      erro_cod    <= ERR_NENHUM;
      erro_estado <= 4'd0;
    end else begin
      prev        <= state_in;
      cafe_pronto <= 1'b0;
      if (self_loop) begin
        if (hold_cnt < HOLD_W'(MAX_HOLD + 1)) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end else begin
        hold_cnt <= HOLD_W'(1);
      end

      if (clear) begin
        erro        <= 1'b0;
        erro_cod    <= ERR_NENHUM;
        erro_estado <= 4'd0;
        cafes_total <= '0;
        ciclo_len   <= '0;
        em_ciclo    <= 1'b0;
        case (estado)
          MON_IDLE:  estado <= MON_IDLE;
          MON_CICLO: estado <= MON_SYNC;
          MON_ERRO:  estado <= (state_in == IDLE) ? MON_IDLE : MON_SYNC;
          MON_SYNC:  estado <= MON_SYNC;
          default:   estado <= MON_IDLE;
        endcase
      end else begin
        case (estado)
          MON_IDLE: begin
            if (viol_cod != ERR_NENHUM) begin
              estado      <= MON_ERRO;
              erro        <= 1'b1;
              erro_cod    <= viol_cod;
              erro_estado <= state_in;
            end else if ((prev == IDLE) && (state_in == LIGAR)) begin
              estado     <= MON_CICLO;
              em_ciclo   <= 1'b1;
              len_cnt    <= 8'd1;
              refill_cnt <= '0;
            end
          end
          MON_CICLO: begin
            if (viol_cod != ERR_NENHUM) begin
              estado      <= MON_ERRO;
              em_ciclo    <= 1'b0;
              erro        <= 1'b1;
              erro_cod    <= viol_cod;
              erro_estado <= state_in;
            end else if ((prev == REALIZAR_EXTRACAO) && (state_in == IDLE)) begin
              estado      <= MON_IDLE;
              em_ciclo    <= 1'b0;
              cafe_pronto <= 1'b1;
              cafes_total <= cafes_total + CNT_W'(1);
              ciclo_len   <= len_cnt;
            end else begin
              if (len_cnt != 8'd255) begin
                len_cnt <= len_cnt + 8'd1;
              end
              if (entra_encher && (refill_cnt < REF_W'(MAX_REFILLS + 1))) begin
                refill_cnt <= refill_cnt + REF_W'(1);
              end
            end
          end
          MON_ERRO: begin
            estado <= MON_ERRO;
          end
          MON_SYNC: begin
            if (state_in == IDLE) begin
              estado <= MON_IDLE;
            end
          end
          default: begin
            estado <= MON_IDLE;
          end
        endcase
      end
    end
  end

endmodule
